// File: rtl/bus_gate_arbiter.sv
// Round-robin arbiter driving the GATE/DIN pins of N shared-bus tri-state lane drivers.
// Every tenure is followed by one all-low TURN cycle, so two drivers never overlap on the bus.
module bus_gate_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       data,
   output logic [N-1:0]         gate,
   output logic [N*W-1:0]       din,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy
);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [IW:0] N_EXT = (IW+1)'(N);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic            busy_q, busy_d;
   logic [N-1:0]    gate_q, gate_d;
   logic [N*W-1:0]  din_q, din_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic            load;
   logic [IW-1:0]   sel;

   // First requester at or above ptr_q, wrapping around the lane count.
   always_comb begin
      logic [IW:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!win_found && req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hcnt_d  = hcnt_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      load    = 1'b0;
      sel     = owner_q;
      case (state_q)
         GRANT: begin
            if (!req[owner_q] || hcnt_q == HW'(MAX_HOLD)) begin
               state_d = TURN;
               ptr_d   = (owner_q == IW'(N-1)) ? '0 : owner_q + IW'(1);
            end else begin
               hcnt_d = hcnt_q + HW'(1);
               load   = 1'b1;
            end
         end
         default: begin
            // IDLE and TURN share the arbitration path; TURN already sees the advanced ptr.
            if (win_found) begin
               state_d = GRANT;
               owner_d = win_idx;
               hcnt_d  = HW'(1);
               busy_d  = 1'b1;
               load    = 1'b1;
               sel     = win_idx;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign gate_d[gi]          = load && (sel == IW'(gi));
         assign din_d[gi*W +: W]    = gate_d[gi] ? data[gi*W +: W] : '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hcnt_q  <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         gate_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hcnt_q  <= hcnt_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         gate_q  <= gate_d;
         din_q   <= din_d;
      end
   end

   assign gate  = gate_q;
   assign gnt   = gate_q;
   assign din   = din_q;
   assign owner = owner_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter with N=4, W=8, MAX_HOLD=4.
module tb_bus_gate_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int MAX_HOLD = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data;
   logic [N-1:0]   gate;
   logic [N*W-1:0] din;
   logic [N-1:0]   gnt;
   logic [1:0]     owner;
   logic           busy;

   int vec_count = 0;
   int err_count = 0;

   bus_gate_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data),
      .gate(gate), .din(din), .gnt(gnt), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      data = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = '0;
      data = '0;
      #2;
      vec_count++;
      if (gate !== 4'b0 || gnt !== 4'b0 || din !== 32'h0 || owner !== 2'd0 || busy !== 1'b0) begin
         err_count++;
         $display("FAIL reset_state: gate=%b gnt=%b din=%h owner=%0d busy=%b required all zero",
                  gate, gnt, din, owner, busy);
      end
      step();
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [N-1:0] exp_gate [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic         exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      req = 4'b0001;
      data[0 +: 8] = 8'hA5;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 1) req = 4'b0000;
         vec_count++;
         if (gate !== exp_gate[c] || busy !== exp_busy[c] || gnt !== gate) begin
            err_count++;
            $display("FAIL single_c%0d: gate=%b gnt=%b busy=%b required gate=%b busy=%b",
                     c, gate, gnt, busy, exp_gate[c], exp_busy[c]);
         end
         if (c == 1) begin
            vec_count++;
            if (din !== 32'h0000_00A5) begin
               err_count++;
               $display("FAIL single_din: din=%h required 000000a5", din);
            end
         end
         if (c >= 2) begin
            vec_count++;
            if (din !== 32'h0) begin
               err_count++;
               $display("FAIL single_din_clear_c%0d: din=%h required 0", c, din);
            end
         end
      end
      $display("test_single done");
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 24; c++) begin
         step();
         exp = ((c % 5) == 4) ? 4'b0000 : 4'(4'b0001 << ((c / 5) % 4));
         vec_count++;
         if (gate !== exp || gnt !== gate || $countones(gate) > 1 || busy !== 1'b1) begin
            err_count++;
            $display("FAIL round_robin_c%0d: gate=%b gnt=%b busy=%b required gate=%b busy=1",
                     c, gate, gnt, busy, exp);
         end
      end
      req = '0;
      $display("test_round_robin done");
   endtask

   task automatic test_hold_regrant();
      logic [N-1:0] exp;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 11; c++) begin
         step();
         exp = ((c % 5) == 4) ? 4'b0000 : 4'b0100;
         vec_count++;
         if (gate !== exp || owner !== 2'd2 || busy !== 1'b1) begin
            err_count++;
            $display("FAIL hold_regrant_c%0d: gate=%b owner=%0d busy=%b required gate=%b owner=2 busy=1",
                     c, gate, owner, busy, exp);
         end
      end
      req = '0;
      $display("test_hold_regrant done");
   endtask

   task automatic test_async_reset();
      do_reset();
      // Grant lane 1 briefly so the pointer advances to 2.
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
      step();
      data[24 +: 8] = 8'h3C;
      req = 4'b1000;
      step();
      step();
      vec_count++;
      if (gate !== 4'b1000 || owner !== 2'd3 || din !== 32'h3C00_0000) begin
         err_count++;
         $display("FAIL lane3_grant: gate=%b owner=%0d din=%h required gate=1000 owner=3 din=3c000000",
                  gate, owner, din);
      end
      #2;
      rst = 1'b1;
      #1;
      vec_count++;
      if (gate !== 4'b0 || gnt !== 4'b0 || din !== 32'h0 || busy !== 1'b0 || owner !== 2'd0) begin
         err_count++;
         $display("FAIL async_reset: gate=%b gnt=%b din=%h busy=%b owner=%0d required all zero",
                  gate, gnt, din, busy, owner);
      end
      #1;
      rst  = 1'b0;
      data = '0;
      req  = 4'b1111;
      step();
      vec_count++;
      if (gate !== 4'b0001 || owner !== 2'd0) begin
         err_count++;
         $display("FAIL ptr_after_reset: gate=%b owner=%0d required gate=0001 owner=0", gate, owner);
      end
      req = '0;
      $display("test_async_reset done");
   endtask

   task automatic test_drop_at_expiry();
      do_reset();
      req = 4'b0010;
      step();
      req = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         vec_count++;
         if (gate !== 4'b0010 || owner !== 2'd1) begin
            err_count++;
            $display("FAIL lane1_tenure_c%0d: gate=%b owner=%0d required gate=0010 owner=1",
                     c, gate, owner);
         end
      end
      req = 4'b0001;
      step();
      vec_count++;
      if (gate !== 4'b0000 || busy !== 1'b1 || owner !== 2'd1) begin
         err_count++;
         $display("FAIL expiry_turn: gate=%b busy=%b owner=%0d required gate=0000 busy=1 owner=1",
                  gate, busy, owner);
      end
      step();
      vec_count++;
      if (gate !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
         err_count++;
         $display("FAIL wrap_to_lane0: gate=%b owner=%0d busy=%b required gate=0001 owner=0 busy=1",
                  gate, owner, busy);
      end
      req = '0;
      $display("test_drop_at_expiry done");
   endtask

   task automatic test_nonowner_data();
      do_reset();
      req = 4'b0001;
      data[0 +: 8] = 8'h11;
      for (int c = 0; c < 4; c++) begin
         data[16 +: 8] = (c % 2 == 0) ? 8'hFF : 8'h5A;
         step();
         vec_count++;
         if (din[16 +: 8] !== 8'h00 || gate[2] !== 1'b0 || gate !== 4'b0001) begin
            err_count++;
            $display("FAIL nonowner_c%0d: din2=%h gate=%b required din2=00 gate=0001",
                     c, din[16 +: 8], gate);
         end
         if (c >= 1) begin
            vec_count++;
            if (din[0 +: 8] !== 8'h11) begin
               err_count++;
               $display("FAIL owner_din_c%0d: din0=%h required 11", c, din[0 +: 8]);
            end
         end
      end
      req  = '0;
      data = '0;
      $display("test_nonowner_data done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_hold_regrant();
      test_async_reset();
      test_drop_at_expiry();
      test_nonowner_data();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule
